// File: rtl/perf_report_pkg.sv
// Shared types and frame layout for the performance-counter telemetry transmitter.
package perf_report_pkg;

    typedef enum logic [1:0] {IDLE, DIV, SEND} state_t;

    localparam int FRAME_LEN = 11;
    localparam int OFS_SYNC  = 0;
    localparam int OFS_TOTAL = 1;
    localparam int OFS_REC   = 5;
    localparam int OFS_PCT   = 9;
    localparam int OFS_CSUM  = 10;
    localparam int PCT_MAX   = 100;
    localparam int NUM_W     = 39;

    // Byte at a given frame offset; counters are sent big-endian, checksum covers bytes 1..9.
    function automatic logic [7:0] frame_byte(input logic [3:0] ofs, input logic [7:0] sync,
                                              input logic [31:0] total, input logic [31:0] rec,
                                              input logic [7:0] pct);
        int o;
        logic [7:0] csum;
        o = int'(ofs);
        csum = pct;
        for (int i = 0; i < 4; i++) csum = csum ^ total[8*i +: 8] ^ rec[8*i +: 8];
        if (o == OFS_SYNC)                  return sync;
        if (o >= OFS_TOTAL && o < OFS_REC)  return total[8*(OFS_REC-1-o) +: 8];
        if (o >= OFS_REC && o < OFS_PCT)    return rec[8*(OFS_PCT-1-o) +: 8];
        if (o == OFS_PCT)                   return pct;
        if (o == OFS_CSUM)                  return csum;
        return 8'h00;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, NUM_W cycles per division.
module seq_divider #(
    parameter int NUM_W = 39,
    parameter int DEN_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quotient,
    output logic [DEN_W-1:0] remainder
);
    localparam int CW = $clog2(NUM_W + 1);

    logic [CW-1:0]  cnt;
    logic [DEN_W-1:0] den;
    logic [DEN_W:0] trial;
    logic [DEN_W:0] diff;

    assign trial = {remainder, quotient[NUM_W-1]};
    assign diff  = trial - {1'b0, den};
    assign busy  = cnt != '0;
    // done marks the final iteration; quotient/remainder are final from the next cycle
    assign done  = cnt == CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            den       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            cnt       <= CW'(NUM_W);
            den       <= divisor;
            quotient  <= numerator;
            remainder <= '0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (!diff[DEN_W]) begin
                remainder <= diff[DEN_W-1:0];
                quotient  <= {quotient[NUM_W-2:0], 1'b1};
            end else begin
                remainder <= trial[DEN_W-1:0];
                quotient  <= {quotient[NUM_W-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/perf_report_tx.sv
// Snapshots the performance counters, computes recovery overhead % and streams an 11-byte frame.
module perf_report_tx
    import perf_report_pkg::*;
#(
    parameter int          REPORT_INTERVAL = 0,
    parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] total_cycle_count,
    input  logic [31:0] recovery_cycle_count,
    input  logic        report_req,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frames_sent
);
    state_t      state;
    logic        pending;
    logic        pct_load;
    logic [3:0]  idx;
    logic [31:0] snap_total;
    logic [31:0] snap_rec;
    logic [7:0]  pct;
    logic        tick;
    logic        trigger;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [NUM_W-1:0] quotient;
    logic [31:0] remainder;
    logic        div_unused;

    if (REPORT_INTERVAL != 0) begin : g_ivl
        logic [31:0] ivl_cnt;
        assign tick = ivl_cnt == 32'(REPORT_INTERVAL - 1);
        always_ff @(posedge clk or posedge reset) begin
            if (reset) ivl_cnt <= '0;
            else       ivl_cnt <= tick ? '0 : ivl_cnt + 32'd1;
        end
    end else begin : g_no_ivl
        assign tick = 1'b0;
    end

    assign trigger    = report_req | tick | pending;
    assign div_start  = (state == IDLE) && trigger && (total_cycle_count != '0);
    assign div_unused = ^{remainder, div_busy};

    seq_divider #(.NUM_W(NUM_W), .DEN_W(32)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .numerator (NUM_W'(recovery_cycle_count) * NUM_W'(PCT_MAX)),
        .divisor   (total_cycle_count),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            pct_load    <= 1'b0;
            idx         <= '0;
            snap_total  <= '0;
            snap_rec    <= '0;
            pct         <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frames_sent <= '0;
        end else begin
            case (state)
                IDLE: if (trigger) begin
                    snap_total <= total_cycle_count;
                    snap_rec   <= recovery_cycle_count;
                    pending    <= 1'b0;
                    busy       <= 1'b1;
                    if (total_cycle_count == '0) begin
                        pct      <= '0;
                        state    <= SEND;
                        tx_valid <= 1'b1;
                        tx_data  <= SYNC_BYTE;
                        idx      <= '0;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: begin
                    if (report_req | tick) pending <= 1'b1;
                    if (div_done) begin
                        state    <= SEND;
                        tx_valid <= 1'b1;
                        tx_data  <= SYNC_BYTE;
                        idx      <= '0;
                        pct_load <= 1'b1;
                    end
                end
                SEND: begin
                    if (report_req | tick) pending <= 1'b1;
                    // quotient settles one cycle after the last divide step; pct is needed only at byte 9
                    if (pct_load) begin
                        pct      <= (quotient > NUM_W'(PCT_MAX)) ? 8'(PCT_MAX) : quotient[7:0];
                        pct_load <= 1'b0;
                    end
                    if (tx_ready) begin
                        if (idx == 4'(FRAME_LEN - 1)) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            tx_valid    <= 1'b0;
                            tx_data     <= '0;
                            frames_sent <= frames_sent + 16'd1;
                        end else begin
                            idx     <= idx + 4'd1;
                            tx_data <= frame_byte(idx + 4'd1, SYNC_BYTE, snap_total, snap_rec, pct);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_perf_report_tx.sv
// Directed bench for perf_report_tx: frame content, latency, backpressure, coalescing, reset, periodic reports.
module tb_perf_report_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, report_req, tx_ready, tx_valid, busy;
    logic [31:0] total, rec;
    logic [7:0]  tx_data;
    logic [15:0] frames_sent;

    logic        reset_p, tx_ready_p, tx_valid_p, busy_p;
    logic [7:0]  tx_data_p;
    logic [15:0] frames_sent_p;

    int checks = 0;
    int errors = 0;

    perf_report_tx #(.REPORT_INTERVAL(0), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .total_cycle_count(total), .recovery_cycle_count(rec),
        .report_req(report_req), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frames_sent(frames_sent));

    perf_report_tx #(.REPORT_INTERVAL(64), .SYNC_BYTE(8'hA5)) dut_p (
        .clk(clk), .reset(reset_p), .total_cycle_count(32'd1000), .recovery_cycle_count(32'd250),
        .report_req(1'b0), .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p),
        .busy(busy_p), .frames_sent(frames_sent_p));

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // lat = negedges until tx_valid, -1 on timeout
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!tx_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!tx_valid) lat = -1;
    endtask

    task automatic request_and_wait(output int lat);
        int l;
        report_req = 1'b1;
        @(negedge clk);
        report_req = 1'b0;
        wait_valid(l);
        lat = (l < 0) ? -1 : l + 1;
    endtask

    // got[10] holds byte 0; ends on the negedge after the last handshake
    task automatic recv_frame(output logic [10:0][7:0] got, output int drops);
        got = '0;
        drops = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (!tx_valid) drops++;
            got = {got[9:0], tx_data};
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++; if (tx_valid !== 1'b0)     begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d want 0", frames_sent); end
        checks++; if (tx_data !== 8'h00)     begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    endtask

    task automatic test_basic();
        int lat, drops;
        logic [10:0][7:0] got;
        do_reset();
        total = 32'd1000; rec = 32'd250;
        request_and_wait(lat);
        // request cycle plus 39 divide cycles precede the first SEND cycle
        checks++; if (lat != 40) begin errors++; $display("FAIL basic_latency: got %0d want 40", lat); end
        recv_frame(got, drops);
        checks++; if (got !== 88'hA5_00_00_03_E8_00_00_00_FA_19_08)
            begin errors++; $display("FAIL basic_frame: got %h want a5000003e8000000fa1908", got); end
        checks++; if (drops != 0) begin errors++; $display("FAIL basic_valid_drop: got %0d want 0", drops); end
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL basic_idle: got valid=%b busy=%b want 0 0", tx_valid, busy); end
        checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL basic_frames: got %0d want 1", frames_sent); end
    endtask

    task automatic test_zero();
        int lat, drops;
        logic [10:0][7:0] got;
        do_reset();
        total = 32'd0; rec = 32'd0;
        request_and_wait(lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL zero_latency: got %0d want 1", lat); end
        recv_frame(got, drops);
        checks++; if (got !== 88'hA5_00_00_00_00_00_00_00_00_00_00)
            begin errors++; $display("FAIL zero_frame: got %h want a500000000000000000000", got); end
        checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL zero_frames: got %0d want 1", frames_sent); end
    endtask

    task automatic test_saturation();
        int lat, drops;
        logic [10:0][7:0] got;
        do_reset();
        total = 32'd10; rec = 32'd20;
        request_and_wait(lat);
        recv_frame(got, drops);
        checks++; if (got[1] !== 8'h64) begin errors++; $display("FAIL sat_pct: got %h want 64", got[1]); end
        checks++; if (got[0] !== 8'h7A) begin errors++; $display("FAIL sat_csum: got %h want 7a", got[0]); end
        checks++; if (got !== 88'hA5_00_00_00_0A_00_00_00_14_64_7A)
            begin errors++; $display("FAIL sat_frame: got %h want a50000000a00000014647a", got); end
    endtask

    task automatic test_backpressure();
        int lat, n, stall, guard, bad;
        logic [10:0][7:0] got;
        do_reset();
        total = 32'd1000; rec = 32'd250;
        request_and_wait(lat);
        got = '0; n = 0; stall = 0; guard = 0; bad = 0;
        while (n < 11 && guard < 100) begin
            if (n == 3 && stall < 5) begin
                tx_ready = 1'b0;
                if (stall > 0) begin
                    checks++;
                    if (tx_data !== 8'h03 || tx_valid !== 1'b1) begin
                        errors++; $display("FAIL bp_hold: got data=%h valid=%b want 03 1", tx_data, tx_valid);
                    end
                end
                stall++;
            end else begin
                tx_ready = 1'b1;
                if (!tx_valid) bad++;
                got = {got[9:0], tx_data};
                n++;
            end
            @(negedge clk);
            guard++;
        end
        tx_ready = 1'b1;
        checks++; if (got !== 88'hA5_00_00_03_E8_00_00_00_FA_19_08)
            begin errors++; $display("FAIL bp_frame: got %h want a5000003e8000000fa1908", got); end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_valid_drop: got %0d want 0", bad); end
        checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL bp_frames: got %0d want 1", frames_sent); end
    endtask

    task automatic test_coalesce();
        int lat, drops, extra;
        logic [10:0][7:0] got;
        do_reset();
        total = 32'd1000; rec = 32'd250;
        report_req = 1'b1;
        @(negedge clk);
        report_req = 1'b0;
        total = 32'd2000; rec = 32'd500;
        for (int k = 0; k < 3; k++) begin
            repeat (4) @(negedge clk);
            report_req = 1'b1;
            @(negedge clk);
            report_req = 1'b0;
        end
        wait_valid(lat);
        recv_frame(got, drops);
        checks++; if (got !== 88'hA5_00_00_03_E8_00_00_00_FA_19_08)
            begin errors++; $display("FAIL coal_frame1: got %h want a5000003e8000000fa1908", got); end
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0)
            begin errors++; $display("FAIL coal_idle: got busy=%b valid=%b want 0 0", busy, tx_valid); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coal_restart: got busy=%b want 1", busy); end
        wait_valid(lat);
        checks++; if (lat < 0) begin errors++; $display("FAIL coal_timeout: got %0d want >=0", lat); end
        recv_frame(got, drops);
        checks++; if (got !== 88'hA5_00_00_07_D0_00_00_01_F4_19_3B)
            begin errors++; $display("FAIL coal_frame2: got %h want a5000007d0000001f4193b", got); end
        extra = 0;
        repeat (80) begin
            if (tx_valid) extra++;
            @(negedge clk);
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL coal_extra: got %0d want 0", extra); end
        checks++; if (frames_sent !== 16'd2) begin errors++; $display("FAIL coal_frames: got %0d want 2", frames_sent); end
    endtask

    task automatic test_reset_midframe();
        int lat, drops, resumed;
        logic [10:0][7:0] got;
        do_reset();
        total = 32'd1000; rec = 32'd250;
        request_and_wait(lat);
        recv_frame(got, drops);
        request_and_wait(lat);
        repeat (6) @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || frames_sent !== 16'd1)
            begin errors++; $display("FAIL mid_pre: got valid=%b frames=%0d want 1 1", tx_valid, frames_sent); end
        reset = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", tx_valid); end
        checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL mid_frames: got %0d want 0", frames_sent); end
        @(negedge clk);
        reset = 1'b0;
        resumed = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_valid || busy) resumed++;
        end
        checks++; if (resumed != 0) begin errors++; $display("FAIL mid_resume: got %0d want 0", resumed); end
    endtask

    task automatic test_periodic();
        int n, k;
        int starts[3];
        logic prev;
        starts = '{-1, -1, -1};
        tx_ready_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        n = 0; k = 0; prev = 1'b0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (tx_valid_p && !prev && k < 3) begin starts[k] = n; k++; end
            prev = tx_valid_p;
        end
        // tick on the 64th edge after release, then 39 divide cycles
        checks++; if (starts[0] != 103) begin errors++; $display("FAIL per_first: got %0d want 103", starts[0]); end
        checks++; if (starts[1] - starts[0] != 64) begin errors++; $display("FAIL per_gap1: got %0d want 64", starts[1] - starts[0]); end
        checks++; if (starts[2] - starts[1] != 64) begin errors++; $display("FAIL per_gap2: got %0d want 64", starts[2] - starts[1]); end
        checks++; if (frames_sent_p !== 16'd3) begin errors++; $display("FAIL per_frames: got %0d want 3", frames_sent_p); end
    endtask

    initial begin
        reset = 1'b1; reset_p = 1'b1;
        report_req = 1'b0; tx_ready = 1'b1; tx_ready_p = 1'b1;
        total = '0; rec = '0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_basic();
        test_zero();
        test_saturation();
        test_backpressure();
        test_coalesce();
        test_reset_midframe();
        test_periodic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
